mem_arbiter: RTL and testbench

- Shares one main-memory port between the instruction cache refill path and the data cache refill/write-back path.
- Grants one requester at a time and latches its address, data and operation.
- Sequences a fixed-latency memory transaction, then returns the 128-bit line with a one-cycle done pulse.
- Sits between both cache controllers and the memory model. It replaces the per-cache chained latency counters.

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle between the two cache refill paths, the arbiter and main memory.
// master = arbiter side, slave = caches/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              ic_req_rd;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_done;
    logic [LINE_W-1:0] ic_rdata;
    logic              dc_req_rd;
    logic              dc_req_wr;
    logic [ADDR_W-1:0] dc_addr;
    logic [LINE_W-1:0] dc_wdata;
    logic              dc_done;
    logic [LINE_W-1:0] dc_rdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              busy;
    logic              owner;

    modport master (
        input  ic_req_rd, ic_addr, dc_req_rd, dc_req_wr, dc_addr, dc_wdata, mem_rdata,
        output ic_done, ic_rdata, dc_done, dc_rdata, mem_rd, mem_wr, mem_addr, mem_wdata,
               busy, owner
    );

    modport slave (
        output ic_req_rd, ic_addr, dc_req_rd, dc_req_wr, dc_addr, dc_wdata, mem_rdata,
        input  ic_done, ic_rdata, dc_done, dc_rdata, mem_rd, mem_wr, mem_addr, mem_wdata,
               busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between I-cache and D-cache.
// All outputs are registered; one transaction in flight at a time.
module mem_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d;
    logic [LINE_W-1:0] dc_rdata_q, dc_rdata_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              ic_done_q, ic_done_d;
    logic              dc_done_q, dc_done_d;
    logic              busy_q, busy_d;

    logic ic_req, dc_req, pick_dc;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        owner_d    = owner_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ic_rdata_d = ic_rdata_q;
        dc_rdata_d = dc_rdata_q;
        mem_rd_d   = 1'b0;
        mem_wr_d   = 1'b0;
        ic_done_d  = 1'b0;
        dc_done_d  = 1'b0;
        ic_req     = bus.ic_req_rd;
        dc_req     = bus.dc_req_rd | bus.dc_req_wr;
        // On a tie the requester not served last wins
        pick_dc    = dc_req & (~ic_req | ~last_q);

        unique case (state_q)
            IDLE: begin
                if (ic_req || dc_req) begin
                    owner_d  = pick_dc;
                    last_d   = pick_dc;
                    wr_d     = pick_dc & bus.dc_req_wr;
                    addr_d   = pick_dc ? bus.dc_addr : bus.ic_addr;
                    if (pick_dc) wdata_d = bus.dc_wdata;
                    mem_rd_d = ~(pick_dc & bus.dc_req_wr);
                    mem_wr_d = pick_dc & bus.dc_req_wr;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 4'(MEM_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (!wr_q) begin
                        if (owner_q) dc_rdata_d = bus.mem_rdata;
                        else         ic_rdata_d = bus.mem_rdata;
                    end
                    ic_done_d = ~owner_q;
                    dc_done_d = owner_q;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            owner_q    <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            ic_done_q  <= 1'b0;
            dc_done_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ic_rdata_q <= ic_rdata_d;
            dc_rdata_q <= dc_rdata_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            ic_done_q  <= ic_done_d;
            dc_done_q  <= dc_done_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.ic_done   = ic_done_q;
    assign bus.ic_rdata  = ic_rdata_q;
    assign bus.dc_done   = dc_done_q;
    assign bus.dc_rdata  = dc_rdata_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level timing model with random cache agents,
// directed scenarios, and a second instance at MEM_LAT=1.
module tb_mem_arbiter;
    localparam int L  = 4;
    localparam int AW = 32;
    localparam int LW = 128;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();
    mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) b1 ();

    mem_arbiter #(.MEM_LAT(L), .ADDR_W(AW), .LINE_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus.master));
    mem_arbiter #(.MEM_LAT(1), .ADDR_W(AW), .LINE_W(LW)) dut1 (.clk(clk), .rst(rst), .bus(b1.master));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: one transaction granted in cycle m_g; strobe at g+1, done at g+L+2, idle again at g+L+3
    bit          m_act, m_own, m_wr, m_last, x_owner;
    int          m_g;
    logic [31:0] x_addr;
    logic [127:0] m_wd, m_line, x_icr, x_dcr, fix_line;
    bit          auto_en, hold, fix_en;
    bit          e_busy, e_stb, e_icd, e_dcd;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_act = 0; m_last = 0; x_owner = 0; x_addr = '0; x_icr = '0; x_dcr = '0;
    endtask

    task automatic check();
        if (m_act && cyc > m_g + L + 2) m_act = 0;
        e_busy = m_act && cyc >= m_g + 1 && cyc <= m_g + L + 2;
        e_stb  = m_act && cyc == m_g + 1;
        e_icd  = m_act && cyc == m_g + L + 2 && !m_own;
        e_dcd  = m_act && cyc == m_g + L + 2 && m_own;
        if (m_act && cyc == m_g + L + 2 && !m_wr) begin
            if (m_own) x_dcr = m_line;
            else       x_icr = m_line;
        end
        chk("busy",     128'(bus.busy),     128'(e_busy));
        chk("mem_rd",   128'(bus.mem_rd),   128'(e_stb && !m_wr));
        chk("mem_wr",   128'(bus.mem_wr),   128'(e_stb && m_wr));
        chk("ic_done",  128'(bus.ic_done),  128'(e_icd));
        chk("dc_done",  128'(bus.dc_done),  128'(e_dcd));
        chk("owner",    128'(bus.owner),    128'(x_owner));
        chk("mem_addr", 128'(bus.mem_addr), 128'(x_addr));
        if (e_stb && m_wr) chk("mem_wdata", bus.mem_wdata, m_wd);
        chk("ic_rdata", bus.ic_rdata, x_icr);
        chk("dc_rdata", bus.dc_rdata, x_dcr);
    endtask

    task automatic agents();
        int k;
        if (e_icd) bus.ic_req_rd = 1'b0;
        if (!bus.ic_req_rd && !e_icd && (hold || (auto_en && $urandom_range(0, 99) < 25))) begin
            bus.ic_req_rd = 1'b1;
            bus.ic_addr   = $urandom & ~32'hF;
        end
        if (e_dcd) begin bus.dc_req_rd = 1'b0; bus.dc_req_wr = 1'b0; end
        if (!(bus.dc_req_rd || bus.dc_req_wr) && !e_dcd &&
            (hold || (auto_en && $urandom_range(0, 99) < 25))) begin
            k = $urandom_range(0, 2);
            bus.dc_req_rd = (k != 1);
            bus.dc_req_wr = (k != 0);
            bus.dc_addr   = $urandom & ~32'hF;
            bus.dc_wdata  = rnd128();
        end
    endtask

    // Grant decision for the current cycle, then memory response for it
    task automatic finish();
        bit ic, dc, pd;
        if (rst && !m_act) begin
            ic = bus.ic_req_rd;
            dc = bus.dc_req_rd || bus.dc_req_wr;
            if (ic || dc) begin
                pd      = (ic && dc) ? !m_last : dc;
                m_act   = 1; m_g = cyc; m_own = pd; m_last = pd; x_owner = pd;
                m_wr    = pd && bus.dc_req_wr;
                x_addr  = pd ? bus.dc_addr : bus.ic_addr;
                m_wd    = bus.dc_wdata;
                m_line  = fix_en ? fix_line : rnd128();
            end
        end
        if (m_act && !m_wr && cyc == m_g + 1 + L) bus.mem_rdata = m_line;
        else                                    bus.mem_rdata = rnd128();
    endtask

    task automatic step();
        finish();
        @(negedge clk);
        cyc++;
        check();
        agents();
    endtask

    // which: 0 ic_done, 1 dc_done, 2 any strobe
    task automatic wait_sig(input int which, input int maxc, output int at);
        bit hit;
        hit = 0; at = -1;
        for (int i = 0; i < maxc && !hit; i++) begin
            step();
            case (which)
                0:       hit = bus.ic_done;
                1:       hit = bus.dc_done;
                default: hit = bus.mem_rd || bus.mem_wr;
            endcase
            if (hit) at = cyc;
        end
        if (!hit) begin
            total++; bad++;
            $error("FAIL wait_timeout which=%0d observed=none expected=event within %0d cycles", which, maxc);
        end
    endtask

    initial begin
        int c0, t, td, ts, s1, d1;
        bit saw;
        logic [127:0] k1;
        bit own_seq[4];
        bus.ic_req_rd = 0; bus.ic_addr = '0; bus.dc_req_rd = 0; bus.dc_req_wr = 0;
        bus.dc_addr = '0; bus.dc_wdata = '0; bus.mem_rdata = '0;
        b1.ic_req_rd = 0; b1.ic_addr = '0; b1.dc_req_rd = 0; b1.dc_req_wr = 0;
        b1.dc_addr = '0; b1.dc_wdata = '0; b1.mem_rdata = '0;
        auto_en = 0; hold = 0; fix_en = 0; fix_line = '0;
        model_reset();

        step(); step();
        rst = 1'b1;
        step();

        // Single I-cache read
        fix_en = 1; fix_line = {8{16'hAAAA}};
        bus.ic_req_rd = 1; bus.ic_addr = 32'h40; c0 = cyc;
        wait_sig(2, 10, t);
        chk("t1_strobe_cycle", 128'(t - c0), 128'(1));
        chk("t1_mem_addr", 128'(bus.mem_addr), 128'(32'h40));
        wait_sig(0, 10, t);
        chk("t1_done_cycle", 128'(t - c0), 128'(6));
        step();
        chk("t1_ic_rdata", bus.ic_rdata, fix_line);
        chk("t1_dc_rdata", bus.dc_rdata, 128'(0));

        // D-cache write-back then refill
        bus.dc_req_wr = 1; bus.dc_addr = 32'h100; bus.dc_wdata = {4{32'h12345678}};
        wait_sig(2, 10, t);
        chk("t2_mem_wr", 128'(bus.mem_wr), 128'(1));
        chk("t2_wdata", bus.mem_wdata, {4{32'h12345678}});
        wait_sig(1, 10, td);
        step();
        chk("t2_dc_rdata_keep", bus.dc_rdata, 128'(0));
        fix_line = {4{32'hCAFEF00D}};
        bus.dc_req_rd = 1; bus.dc_addr = 32'h200;
        wait_sig(2, 10, ts);
        chk("t2_rd_gap", 128'(ts - td), 128'(2));
        chk("t2_mem_rd", 128'(bus.mem_rd), 128'(1));
        wait_sig(1, 10, t);
        step();
        chk("t2_dc_rdata", bus.dc_rdata, {4{32'hCAFEF00D}});
        fix_en = 0;

        // Tie right after reset: D, I, D, I
        rst = 1'b0; model_reset(); step(); step(); rst = 1'b1;
        hold = 1;
        bus.ic_req_rd = 1; bus.ic_addr = 32'h500;
        bus.dc_req_rd = 1; bus.dc_req_wr = 0; bus.dc_addr = 32'h600;
        for (int i = 0; i < 4; i++) begin
            wait_sig(2, 20, t);
            own_seq[i] = bus.owner;
        end
        chk("t3_grant0", 128'(own_seq[0]), 128'(1));
        chk("t3_grant1", 128'(own_seq[1]), 128'(0));
        chk("t3_grant2", 128'(own_seq[2]), 128'(1));
        chk("t3_grant3", 128'(own_seq[3]), 128'(0));
        hold = 0;
        repeat (30) step();

        // I-cache request arriving during a D-cache read's WAIT
        bus.dc_req_rd = 1; bus.dc_req_wr = 0; bus.dc_addr = 32'h300;
        repeat (3) step();
        bus.ic_req_rd = 1; bus.ic_addr = 32'h340;
        wait_sig(1, 20, td);
        wait_sig(2, 20, ts);
        chk("t4_pending_gap", 128'(ts - td), 128'(2));
        chk("t4_owner", 128'(bus.owner), 128'(0));
        wait_sig(0, 20, t);

        // Random traffic from both agents
        auto_en = 1;
        repeat (600) step();
        auto_en = 0;
        repeat (40) step();

        // Reset in the third WAIT cycle of an I-cache read
        bus.ic_req_rd = 1; bus.ic_addr = 32'h80;
        repeat (4) step();
        rst = 1'b0; model_reset(); bus.ic_req_rd = 0;
        saw = 0;
        repeat (6) begin
            step();
            if (bus.ic_done) saw = 1;
        end
        chk("t5_no_done", 128'(saw), 128'(0));
        chk("t5_busy", 128'(bus.busy), 128'(0));
        chk("t5_ic_rdata", bus.ic_rdata, 128'(0));
        rst = 1'b1;
        step();
        fix_en = 1; fix_line = {4{32'h0BADBEEF}};
        bus.ic_req_rd = 1; bus.ic_addr = 32'hC0; c0 = cyc;
        wait_sig(0, 12, t);
        chk("t5_after_done_cycle", 128'(t - c0), 128'(6));
        step();
        chk("t5_after_rdata", bus.ic_rdata, {4{32'h0BADBEEF}});
        fix_en = 0;

        // MEM_LAT = 1 instance
        k1 = {4{32'h5A5A1111}};
        b1.mem_rdata = k1; b1.ic_addr = 32'h40; b1.ic_req_rd = 1; c0 = cyc;
        s1 = -1; d1 = -1;
        for (int i = 0; i < 10 && d1 < 0; i++) begin
            step();
            if (b1.mem_rd) s1 = cyc;
            if (b1.ic_done) d1 = cyc;
        end
        b1.ic_req_rd = 0;
        chk("t6_strobe_cycle", 128'(s1 - c0), 128'(1));
        chk("t6_done_cycle", 128'(d1 - c0), 128'(3));
        step();
        chk("t6_ic_rdata", b1.ic_rdata, k1);
        chk("t6_busy", 128'(b1.busy), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
